// File: rtl/mux_scan_sequencer.sv
//==============================================================================
// Module   : mux_scan_sequencer
// Brief    : Steps a 4:1 mux select through all channels, samples each after a
//            settle time and presents the 4-bit frame over valid/ready.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_CH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       clr_ovr,
    input  logic       mux_in,
    output logic [1:0] sel,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_CH  = 2'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       ovr_q,   ovr_d;
    logic       ovr_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    sel_d   = 2'd0;
                    cnt_d   = 4'd0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    data_d[sel_q] = mux_in;
                    cnt_d         = 4'd0;
                    if (sel_q == LAST_CH) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    valid_d = 1'b0;
                    if (continuous) begin
                        state_d = S_SETTLE;
                        sel_d   = 2'd0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A single-shot handshake edge is the end of busy, so start there is not an overrun.
    assign ovr_set = start && (state_q != S_IDLE)
                     && !((state_q == S_HOLD) && frame_ready && !continuous);
    assign ovr_d   = ovr_set | (ovr_q & ~clr_ovr);

    assign sel         = sel_q;
    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
//==============================================================================
// Module   : tb_mux_scan_sequencer
// Brief    : Self-checking bench for mux_scan_sequencer (vector table, directed
//            corner sequences and random stimulus against a reference model).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

    localparam int SC   = 2;
    localparam int NCH  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, continuous, clr_ovr, frame_ready;
    logic [3:0] mux_data;
    logic       mux_in;
    logic [1:0] sel;
    logic [3:0] frame_data;
    logic       frame_valid, busy, overrun;

    logic       s1_start;
    logic [3:0] s1_data;
    logic       mux_in1;
    logic [1:0] sel1;
    logic [3:0] frame_data1;
    logic       frame_valid1, busy1, overrun1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_in  = mux_data[sel];
    assign mux_in1 = s1_data[sel1];

    mux_scan_sequencer #(.SETTLE_CYCLES(SC), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .clr_ovr(clr_ovr), .mux_in(mux_in), .sel(sel), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
        .overrun(overrun)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(1), .NUM_CH(NCH)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .continuous(1'b0),
        .clr_ovr(1'b0), .mux_in(mux_in1), .sel(sel1), .frame_data(frame_data1),
        .frame_valid(frame_valid1), .frame_ready(1'b1), .busy(busy1),
        .overrun(overrun1)
    );

    // Reference model: a scan is described by the edge number it started on;
    // elapsed edges divided by the settle time give the channel being visited.
    bit         m_active, m_hold;
    int         m_e0, cyc;
    logic [3:0] m_frame;
    logic       m_ovr;

    function void model_reset();
        m_active = 1'b0;
        m_hold   = 1'b0;
        m_frame  = 4'd0;
        m_ovr    = 1'b0;
    endfunction

    function void model_edge();
        int e;
        cyc++;
        if (start && m_active && !(m_hold && frame_ready && !continuous))
            m_ovr = 1'b1;
        else if (clr_ovr)
            m_ovr = 1'b0;
        if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_e0     = cyc;
            end
        end else if (m_hold) begin
            if (frame_ready) begin
                m_hold = 1'b0;
                if (continuous) m_e0 = cyc;
                else            m_active = 1'b0;
            end
        end else begin
            e = cyc - m_e0;
            if (e % SC == 0) m_frame[e/SC - 1] = mux_data[e/SC - 1];
            if (e == NCH * SC) m_hold = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int exp_sel;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        exp_sel = (m_active && !m_hold) ? (cyc - m_e0) / SC : 0;
        chk("model_sel",   32'(sel),         32'(exp_sel));
        chk("model_valid", 32'(frame_valid), 32'(m_hold));
        chk("model_busy",  32'(busy),        32'(m_active));
        chk("model_data",  32'(frame_data),  32'(m_frame));
        chk("model_ovr",   32'(overrun),     32'(m_ovr));
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic [3:0] data;
        logic [1:0] e_sel;
        logic       e_valid;
        logic       e_busy;
        logic [3:0] e_fd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'hA, 2'd0, 1'b0, 1'b1, 4'h0};
        tbl[1] = '{1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 1'b1, 4'h0};
        tbl[2] = '{1'b0, 1'b1, 4'hA, 2'd1, 1'b0, 1'b1, 4'h0};
        tbl[3] = '{1'b0, 1'b1, 4'hA, 2'd1, 1'b0, 1'b1, 4'h0};
        tbl[4] = '{1'b0, 1'b1, 4'hA, 2'd2, 1'b0, 1'b1, 4'h2};
        tbl[5] = '{1'b0, 1'b1, 4'hA, 2'd2, 1'b0, 1'b1, 4'h2};
        tbl[6] = '{1'b0, 1'b1, 4'hA, 2'd3, 1'b0, 1'b1, 4'h2};
        tbl[7] = '{1'b0, 1'b1, 4'hA, 2'd3, 1'b0, 1'b1, 4'h2};
        tbl[8] = '{1'b0, 1'b1, 4'hA, 2'd0, 1'b1, 1'b1, 4'hA};
        tbl[9] = '{1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 4'hA};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; clr_ovr = 1'b0;
        frame_ready = 1'b0; mux_data = 4'h0; s1_start = 1'b0; s1_data = 4'h0;
        cyc = 0; m_e0 = 0;
        model_reset();
        tick();
        tick();
        chk("rst_sel",   32'(sel),         'h0);
        chk("rst_data",  32'(frame_data),  'h0);
        chk("rst_valid", 32'(frame_valid), 'h0);
        chk("rst_busy",  32'(busy),        'h0);
        chk("rst_ovr",   32'(overrun),     'h0);
        rst = 1'b0;

        // Single scan from the vector table
        for (int i = 0; i < 10; i++) begin
            start       = tbl[i].start;
            frame_ready = tbl[i].ready;
            mux_data    = tbl[i].data;
            tick();
            chk($sformatf("tbl%0d_sel", i),   32'(sel),         32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_valid", i), 32'(frame_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_data", i),  32'(frame_data),  32'(tbl[i].e_fd));
        end

        // Back-pressure: ready low for five cycles after valid
        mux_data = 4'b0110; frame_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            frame_ready = (c == 14);
            tick();
            if (c >= 8 && c <= 13) begin
                chk("bp_valid", 32'(frame_valid), 'h1);
                chk("bp_data",  32'(frame_data),  'h6);
            end
        end
        chk("bp_valid_drop", 32'(frame_valid), 'h0);
        chk("bp_busy_drop",  32'(busy),        'h0);

        // Continuous scanning: two back-to-back frames
        continuous = 1'b1; frame_ready = 1'b1; mux_data = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk("cont_busy", 32'(busy), 'h1);
            if (c == 8) begin
                chk("cont_f0_valid", 32'(frame_valid), 'h1);
                chk("cont_f0_data",  32'(frame_data),  'h1);
                mux_data = 4'b1000;
            end
            if (c == 9) begin
                chk("cont_restart_sel",   32'(sel),         'h0);
                chk("cont_restart_valid", 32'(frame_valid), 'h0);
            end
            if (c == 16) chk("cont_f1_early", 32'(frame_valid), 'h0);
            if (c == 17) begin
                chk("cont_f1_valid", 32'(frame_valid), 'h1);
                chk("cont_f1_data",  32'(frame_data),  'h8);
            end
        end
        continuous = 1'b0;
        tick();
        chk("cont_stop_busy", 32'(busy), 'h0);

        // Overrun: start while busy, then clear, then clear colliding with set
        mux_data = 4'b0011; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovr_set",      32'(overrun), 'h1);
        chk("ovr_scan_sel", 32'(sel),     'h1);
        for (int c = 4; c <= 19; c++) begin
            tick();
            if (c == 8) chk("ovr_frame", 32'(frame_data), 'h3);
        end
        chk("ovr_held", 32'(overrun), 'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear", 32'(overrun), 'h0);
        mux_data = 4'b0101; start = 1'b1;
        tick();
        tick();
        chk("ovr_set2", 32'(overrun), 'h1);
        clr_ovr = 1'b1;
        tick();
        chk("ovr_set_wins", 32'(overrun), 'h1);
        start = 1'b0;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clear2", 32'(overrun), 'h0);
        for (int c = 4; c <= 9; c++) tick();
        chk("ovr_frame2", 32'(frame_data), 'h5);

        // Asynchronous reset in the middle of a scan
        mux_data = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_sel",   32'(sel),         'h0);
        chk("arst_data",  32'(frame_data),  'h0);
        chk("arst_valid", 32'(frame_valid), 'h0);
        chk("arst_busy",  32'(busy),        'h0);
        tick();
        tick();
        rst = 1'b0;
        mux_data = 4'b1001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        chk("arst_new_valid", 32'(frame_valid), 'h1);
        chk("arst_new_data",  32'(frame_data),  'h9);
        tick();

        // Minimum settle time of one cycle
        s1_data = 4'b1111; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("sc1_early", 32'(frame_valid1), 'h0);
        end
        tick();
        chk("sc1_valid", 32'(frame_valid1), 'h1);
        chk("sc1_data",  32'(frame_data1),  'hF);
        tick();
        chk("sc1_idle", 32'(busy1), 'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            mux_data    = 4'($urandom);
            start       = ($urandom_range(0, 7) == 0);
            clr_ovr     = ($urandom_range(0, 9) == 0);
            frame_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) continuous = ~continuous;
            if (m_hold && continuous && frame_ready) start = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
